// File: rtl/exc_seq.sv
// Exception entry/return sequencer.
// Owns the CPSR mode and mask bits and the banked SPSRs. It drives the register
// file's write port, PC write port and one read port to carry out exception
// entry (save status, write the banked r14, load the vector) and exception
// return (read the banked r14, restore status, write PC).
//
// state  | meaning
// IDLE   | sample requests; accept an entry or a return, or reject a return
// ENT_LR | write the latched link value into the banked r14 of the new mode
// ENT_PC | write the vector address into PC, pulse done
// RET_RD | read the banked r14, capture it as the return address
// RET_WR | write the return address into PC, restore {I,F,M}, pulse done
module exc_seq #(
  parameter logic [31:0] VBASE    = 32'h0000_0000,
  parameter logic [4:0]  RST_MODE = 5'b10011
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [5:0]  exc_req_i,
  input  logic        ret_req_i,
  input  logic [31:0] cur_pc_i,
  input  logic [31:0] r_data_i,
  output logic [3:0]  r_addr_o,
  output logic        write_reg_o,
  output logic [3:0]  w_addr_o,
  output logic [31:0] w_data_o,
  output logic        write_pc_o,
  output logic [31:0] pc_data_o,
  output logic [4:0]  m_o,
  output logic        irq_mask_o,
  output logic        fiq_mask_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam logic [3:0] REG_LR = 4'd14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENT_LR = 3'd1,
    ENT_PC = 3'd2,
    RET_RD = 3'd3,
    RET_WR = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  mode_q, mode_d;
  logic        i_q, i_d;
  logic        f_q, f_d;
  logic [6:0]  spsr_fiq_q, spsr_fiq_d;
  logic [6:0]  spsr_irq_q, spsr_irq_d;
  logic [6:0]  spsr_svc_q, spsr_svc_d;
  logic [6:0]  spsr_abt_q, spsr_abt_d;
  logic [6:0]  spsr_und_q, spsr_und_d;
  logic [31:0] lr_q, lr_d;
  logic [31:0] vec_q, vec_d;
  logic [31:0] ret_pc_q, ret_pc_d;

  logic        irq_eff;
  logic        fiq_eff;
  logic        any_exc;
  logic [4:0]  tgt_mode;
  logic [4:0]  tgt_off;
  logic [31:0] tgt_lr_inc;
  logic        tgt_fiq;
  logic [6:0]  cur_status;
  logic [6:0]  spsr_cur;
  logic        ret_illegal;

  // Qualify the maskable sources and pick the highest-priority exception.
  always_comb begin
    irq_eff    = exc_req_i[3] & ~i_q;
    fiq_eff    = exc_req_i[4] & ~f_q;
    any_exc    = exc_req_i[5] | fiq_eff | irq_eff |
                 exc_req_i[2] | exc_req_i[1] | exc_req_i[0];
    tgt_mode   = MODE_SVC;
    tgt_off    = 5'h08;
    tgt_lr_inc = 32'd4;
    tgt_fiq    = 1'b0;
    if (exc_req_i[5]) begin
      tgt_mode   = MODE_ABT;
      tgt_off    = 5'h10;
      tgt_lr_inc = 32'd8;
    end else if (fiq_eff) begin
      tgt_mode   = MODE_FIQ;
      tgt_off    = 5'h1C;
      tgt_fiq    = 1'b1;
    end else if (irq_eff) begin
      tgt_mode   = MODE_IRQ;
      tgt_off    = 5'h18;
    end else if (exc_req_i[2]) begin
      tgt_mode   = MODE_ABT;
      tgt_off    = 5'h0C;
    end else if (exc_req_i[1]) begin
      tgt_mode   = MODE_UND;
      tgt_off    = 5'h04;
    end
  end

  // Current status word and the SPSR banked for the current mode.
  always_comb begin
    cur_status  = {i_q, f_q, mode_q};
    ret_illegal = (mode_q == MODE_USR) || (mode_q == MODE_SYS);
    case (mode_q)
      MODE_FIQ: spsr_cur = spsr_fiq_q;
      MODE_IRQ: spsr_cur = spsr_irq_q;
      MODE_SVC: spsr_cur = spsr_svc_q;
      MODE_ABT: spsr_cur = spsr_abt_q;
      MODE_UND: spsr_cur = spsr_und_q;
      default:  spsr_cur = 7'd0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    i_d         = i_q;
    f_d         = f_q;
    spsr_fiq_d  = spsr_fiq_q;
    spsr_irq_d  = spsr_irq_q;
    spsr_svc_d  = spsr_svc_q;
    spsr_abt_d  = spsr_abt_q;
    spsr_und_d  = spsr_und_q;
    lr_d        = lr_q;
    vec_d       = vec_q;
    ret_pc_d    = ret_pc_q;
    r_addr_o    = 4'd0;
    write_reg_o = 1'b0;
    w_addr_o    = 4'd0;
    w_data_o    = 32'd0;
    write_pc_o  = 1'b0;
    pc_data_o   = 32'd0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_exc) begin
          state_d = ENT_LR;
          case (tgt_mode)
            MODE_FIQ: spsr_fiq_d = cur_status;
            MODE_IRQ: spsr_irq_d = cur_status;
            MODE_ABT: spsr_abt_d = cur_status;
            MODE_UND: spsr_und_d = cur_status;
            default:  spsr_svc_d = cur_status;
          endcase
          mode_d = tgt_mode;
          i_d    = 1'b1;
          if (tgt_fiq) begin
            f_d = 1'b1;
          end
          lr_d  = cur_pc_i + tgt_lr_inc;
          vec_d = VBASE + {27'd0, tgt_off};
        end else if (ret_req_i) begin
          if (ret_illegal) begin
            err_o = 1'b1;
          end else begin
            state_d = RET_RD;
          end
        end
      end

      ENT_LR: begin
        busy_o      = 1'b1;
        r_addr_o    = REG_LR;
        write_reg_o = 1'b1;
        w_addr_o    = REG_LR;
        w_data_o    = lr_q;
        state_d     = ENT_PC;
      end

      ENT_PC: begin
        busy_o     = 1'b1;
        r_addr_o   = REG_LR;
        write_pc_o = 1'b1;
        pc_data_o  = vec_q;
        done_o     = 1'b1;
        state_d    = IDLE;
      end

      RET_RD: begin
        busy_o   = 1'b1;
        r_addr_o = REG_LR;
        ret_pc_d = r_data_i;
        state_d  = RET_WR;
      end

      RET_WR: begin
        busy_o     = 1'b1;
        r_addr_o   = REG_LR;
        write_pc_o = 1'b1;
        pc_data_o  = ret_pc_q;
        done_o     = 1'b1;
        {i_d, f_d, mode_d} = spsr_cur;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, status and latched-operand registers; reset aborts any sequence.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      mode_q     <= RST_MODE;
      i_q        <= 1'b1;
      f_q        <= 1'b1;
      spsr_fiq_q <= 7'd0;
      spsr_irq_q <= 7'd0;
      spsr_svc_q <= 7'd0;
      spsr_abt_q <= 7'd0;
      spsr_und_q <= 7'd0;
      lr_q       <= 32'd0;
      vec_q      <= 32'd0;
      ret_pc_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      i_q        <= i_d;
      f_q        <= f_d;
      spsr_fiq_q <= spsr_fiq_d;
      spsr_irq_q <= spsr_irq_d;
      spsr_svc_q <= spsr_svc_d;
      spsr_abt_q <= spsr_abt_d;
      spsr_und_q <= spsr_und_d;
      lr_q       <= lr_d;
      vec_q      <= vec_d;
      ret_pc_q   <= ret_pc_d;
    end
  end

  assign m_o        = mode_q;
  assign irq_mask_o = i_q;
  assign fiq_mask_o = f_q;

endmodule

// File: tb/tb_exc_seq.sv
// Bench for exc_seq: register-file writes are scoreboarded, status is checked inline.
module tb_exc_seq;

  logic        clk;
  logic        rst_n;
  logic [5:0]  exc_req;
  logic        ret_req;
  logic [31:0] cur_pc;
  logic [31:0] r_data;
  logic [3:0]  r_addr_o;
  logic        write_reg_o;
  logic [3:0]  w_addr_o;
  logic [31:0] w_data_o;
  logic        write_pc_o;
  logic [31:0] pc_data_o;
  logic [4:0]  m_o;
  logic        irq_mask_o;
  logic        fiq_mask_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  // Auxiliary instances that come out of reset in USR and SYS.
  logic [5:0]  exc_aux;
  logic        ret_aux;
  logic [3:0]  u_raddr, s_raddr, u_waddr, s_waddr;
  logic [31:0] u_wdata, s_wdata, u_pcd, s_pcd;
  logic        u_wr, s_wr, u_wp, s_wp, u_im, s_im, u_fm, s_fm;
  logic        u_busy, s_busy, u_done, s_done, u_err, s_err;
  logic [4:0]  u_m, s_m;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic        is_pc;
    logic [3:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  ev_t mon_obs;

  exc_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .exc_req_i(exc_req), .ret_req_i(ret_req),
    .cur_pc_i(cur_pc), .r_data_i(r_data), .r_addr_o(r_addr_o),
    .write_reg_o(write_reg_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .write_pc_o(write_pc_o), .pc_data_o(pc_data_o), .m_o(m_o),
    .irq_mask_o(irq_mask_o), .fiq_mask_o(fiq_mask_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  exc_seq #(.RST_MODE(5'b10000)) dut_usr (
    .clk_i(clk), .rst_ni(rst_n), .exc_req_i(exc_aux), .ret_req_i(ret_aux),
    .cur_pc_i(32'h0), .r_data_i(32'h0), .r_addr_o(u_raddr),
    .write_reg_o(u_wr), .w_addr_o(u_waddr), .w_data_o(u_wdata),
    .write_pc_o(u_wp), .pc_data_o(u_pcd), .m_o(u_m),
    .irq_mask_o(u_im), .fiq_mask_o(u_fm), .busy_o(u_busy),
    .done_o(u_done), .err_o(u_err)
  );

  exc_seq #(.RST_MODE(5'b11111)) dut_sys (
    .clk_i(clk), .rst_ni(rst_n), .exc_req_i(6'd0), .ret_req_i(ret_aux),
    .cur_pc_i(32'h0), .r_data_i(32'h0), .r_addr_o(s_raddr),
    .write_reg_o(s_wr), .w_addr_o(s_waddr), .w_data_o(s_wdata),
    .write_pc_o(s_wp), .pc_data_o(s_pcd), .m_o(s_m),
    .irq_mask_o(s_im), .fiq_mask_o(s_fm), .busy_o(s_busy),
    .done_o(s_done), .err_o(s_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: every register-file or PC write must match the next expected event.
  always @(negedge clk) begin
    if (write_reg_o || write_pc_o) begin
      n_total++;
      if (write_reg_o && write_pc_o)
        $display("FAIL dual_write: write_reg=%b write_pc=%b required not both", write_reg_o, write_pc_o);
      else n_pass++;
      mon_obs.is_pc = write_pc_o;
      mon_obs.addr  = write_pc_o ? 4'd0 : w_addr_o;
      mon_obs.data  = write_pc_o ? pc_data_o : w_data_o;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got pc=%b addr=%0d data=%h with nothing expected",
                 mon_obs.is_pc, mon_obs.addr, mon_obs.data);
      end else begin
        mon_e = sb.pop_front();
        if (mon_obs !== mon_e)
          $display("FAIL sb_write: got pc=%b addr=%0d data=%h want pc=%b addr=%0d data=%h",
                   mon_obs.is_pc, mon_obs.addr, mon_obs.data, mon_e.is_pc, mon_e.addr, mon_e.data);
        else n_pass++;
      end
      if (write_pc_o) begin
        n_total++;
        if (done_o !== 1'b1) $display("FAIL done_with_pc: got %b want 1", done_o);
        else n_pass++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exc_req = 6'd0; ret_req = 1'b0; cur_pc = 32'd0; r_data = 32'd0;
    exc_aux = 6'd0; ret_aux = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic entry_seq(input string nm, input logic [5:0] req, input logic ret,
                           input logic [31:0] pc, input logic [4:0] em,
                           input logic ei, input logic ef,
                           input logic [31:0] lr, input logic [31:0] vec);
    exc_req = req; ret_req = ret; cur_pc = pc;
    sb.push_back('{1'b0, 4'd14, lr});
    sb.push_back('{1'b1, 4'd0, vec});
    n_total++; if (busy_o !== 1'b0) $display("FAIL %s_idle_busy: got %b want 0", nm, busy_o); else n_pass++;
    cyc();
    // ENT_LR: new levels must be ignored and the link value already latched
    exc_req = 6'b100000; ret_req = 1'b1; cur_pc = ~pc;
    n_total++; if (busy_o !== 1'b1) $display("FAIL %s_lr_busy: got %b want 1", nm, busy_o); else n_pass++;
    n_total++; if (m_o !== em) $display("FAIL %s_mode: got %b want %b", nm, m_o, em); else n_pass++;
    n_total++; if ({irq_mask_o, fiq_mask_o} !== {ei, ef})
      $display("FAIL %s_masks: got I=%b F=%b want I=%b F=%b", nm, irq_mask_o, fiq_mask_o, ei, ef);
    else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL %s_lr_done: got %b want 0", nm, done_o); else n_pass++;
    cyc();
    n_total++; if (done_o !== 1'b1) $display("FAIL %s_pc_done: got %b want 1", nm, done_o); else n_pass++;
    cyc();
    exc_req = 6'd0; ret_req = 1'b0;
    n_total++; if ({busy_o, done_o, m_o} !== {2'b00, em})
      $display("FAIL %s_after: got busy=%b done=%b m=%b want 0 0 %b", nm, busy_o, done_o, m_o, em);
    else n_pass++;
  endtask

  task automatic return_seq(input string nm, input logic [31:0] rd, input logic [4:0] m_in,
                            input logic [4:0] em, input logic ei, input logic ef);
    ret_req = 1'b1; r_data = rd;
    sb.push_back('{1'b1, 4'd0, rd});
    n_total++; if ({busy_o, r_addr_o, err_o} !== {1'b0, 4'd0, 1'b0})
      $display("FAIL %s_idle: got busy=%b r_addr=%0d err=%b want 0 0 0", nm, busy_o, r_addr_o, err_o);
    else n_pass++;
    cyc();
    ret_req = 1'b0;
    n_total++; if ({r_addr_o, m_o, busy_o} !== {4'd14, m_in, 1'b1})
      $display("FAIL %s_rd: got r_addr=%0d m=%b busy=%b want 14 %b 1", nm, r_addr_o, m_o, busy_o, m_in);
    else n_pass++;
    cyc();
    r_data = ~rd;
    n_total++; if (done_o !== 1'b1) $display("FAIL %s_wr_done: got %b want 1", nm, done_o); else n_pass++;
    cyc();
    n_total++; if ({m_o, irq_mask_o, fiq_mask_o, r_addr_o, busy_o} !== {em, ei, ef, 4'd0, 1'b0})
      $display("FAIL %s_restore: got m=%b I=%b F=%b r_addr=%0d busy=%b want %b %b %b 0 0",
               nm, m_o, irq_mask_o, fiq_mask_o, r_addr_o, busy_o, em, ei, ef);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    exc_req = 6'd0; ret_req = 1'b0; cur_pc = 32'd0; r_data = 32'd0;
    exc_aux = 6'd0; ret_aux = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({m_o, irq_mask_o, fiq_mask_o} !== {5'b10011, 2'b11})
      $display("FAIL reset_status: got m=%b I=%b F=%b want 10011 1 1", m_o, irq_mask_o, fiq_mask_o);
    else n_pass++;
    n_total++; if ({write_reg_o, write_pc_o, done_o, err_o, busy_o} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {write_reg_o, write_pc_o, done_o, err_o, busy_o});
    else n_pass++;
    n_total++; if ({r_addr_o, w_addr_o, w_data_o, pc_data_o} !== 72'd0)
      $display("FAIL reset_data: got r=%0d w=%0d wd=%h pd=%h want zeros", r_addr_o, w_addr_o, w_data_o, pc_data_o);
    else n_pass++;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_irq_masked();
    exc_req = 6'b001000; cur_pc = 32'h0000_2000;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_total++; if ({busy_o, m_o} !== {1'b0, 5'b10010})
        $display("FAIL irq_masked_%0d: got busy=%b m=%b want 0 10010", k, busy_o, m_o);
      else n_pass++;
    end
    exc_req = 6'd0;
  endtask

  task automatic test_ret_reject();
    ret_aux = 1'b1;
    #1;
    n_total++; if ({u_err, s_err, u_busy, s_busy} !== 4'b1100)
      $display("FAIL reject_pulse: got err u=%b s=%b busy u=%b s=%b want 1 1 0 0", u_err, s_err, u_busy, s_busy);
    else n_pass++;
    cyc();
    ret_aux = 1'b0;
    #1;
    n_total++; if ({u_err, s_err, u_busy, s_busy, u_wr, u_wp, s_wr, s_wp} !== 8'd0)
      $display("FAIL reject_after: got %b want 00000000", {u_err, s_err, u_busy, s_busy, u_wr, u_wp, s_wr, s_wp});
    else n_pass++;
    n_total++; if ({u_m, s_m} !== {5'b10000, 5'b11111})
      $display("FAIL reject_mode: got u=%b s=%b want 10000 11111", u_m, s_m);
    else n_pass++;
    // An exception in USR wins over a simultaneous return: no err, entry starts
    exc_aux = 6'b000001; ret_aux = 1'b1;
    #1;
    n_total++; if (u_err !== 1'b0) $display("FAIL usr_exc_beats_ret_err: got %b want 0", u_err); else n_pass++;
    cyc();
    exc_aux = 6'd0; ret_aux = 1'b0;
    n_total++; if ({u_busy, u_wr, u_m} !== {2'b11, 5'b10011})
      $display("FAIL usr_exc_beats_ret: got busy=%b wr=%b m=%b want 1 1 10011", u_busy, u_wr, u_m);
    else n_pass++;
    cyc();
    cyc();
  endtask

  task automatic test_reset_abort();
    apply_reset();
    exc_req = 6'b000001; cur_pc = 32'h0000_9000;
    sb.push_back('{1'b0, 4'd14, 32'h0000_9004});
    cyc();
    exc_req = 6'd0;
    #6 rst_n = 1'b0;
    #1;
    n_total++; if ({write_reg_o, write_pc_o, busy_o, r_addr_o, w_addr_o, w_data_o} !== 43'd0)
      $display("FAIL abort_outputs: got wr=%b wp=%b busy=%b r=%0d w=%0d wd=%h want zeros",
               write_reg_o, write_pc_o, busy_o, r_addr_o, w_addr_o, w_data_o);
    else n_pass++;
    n_total++; if ({m_o, irq_mask_o, fiq_mask_o} !== {5'b10011, 2'b11})
      $display("FAIL abort_status: got m=%b I=%b F=%b want 10011 1 1", m_o, irq_mask_o, fiq_mask_o);
    else n_pass++;
    n_total++; if (sb.size() != 0) $display("FAIL abort_lr_seen: got %0d pending want 0", sb.size()); else n_pass++;
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    n_total++; if (busy_o !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", busy_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    // SVC entry from reset; the return then restores SPSR_svc = 1110011
    entry_seq("svc", 6'b000001, 1'b0, 32'h0000_0100, 5'b10011, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_0008);
    return_seq("svc_ret", 32'h0000_0104, 5'b10011, 5'b10011, 1'b1, 1'b1);
    // Fresh reset: SPSR_svc is zero, so a return clears both masks
    apply_reset();
    return_seq("unmask", 32'h0000_ABC0, 5'b10011, 5'b00000, 1'b0, 1'b0);
    entry_seq("irq", 6'b001000, 1'b0, 32'h0000_2000, 5'b10010, 1'b1, 1'b0, 32'h0000_2004, 32'h0000_0018);
    test_irq_masked();
    return_seq("irq_ret", 32'h0000_2004, 5'b10010, 5'b00000, 1'b0, 1'b0);
    entry_seq("fiq", 6'b010000, 1'b0, 32'h0000_3000, 5'b10001, 1'b1, 1'b1, 32'h0000_3004, 32'h0000_001C);
    return_seq("fiq_ret", 32'h0000_3004, 5'b10001, 5'b00000, 1'b0, 1'b0);
    // Priority chain of nested entries, each accepted on the first IDLE cycle
    entry_seq("all_dabt", 6'b111111, 1'b0, 32'hFFFF_FFFA, 5'b10111, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0010);
    entry_seq("fiq_wins", 6'b011111, 1'b0, 32'h0000_5000, 5'b10001, 1'b1, 1'b1, 32'h0000_5004, 32'h0000_001C);
    entry_seq("pabt_wins", 6'b001110, 1'b0, 32'h0000_6000, 5'b10111, 1'b1, 1'b1, 32'h0000_6004, 32'h0000_000C);
    entry_seq("und_beats_ret", 6'b000011, 1'b1, 32'h0000_7000, 5'b11011, 1'b1, 1'b1, 32'h0000_7004, 32'h0000_0004);
    entry_seq("svc_nested", 6'b000001, 1'b0, 32'h0000_8000, 5'b10011, 1'b1, 1'b1, 32'h0000_8004, 32'h0000_0008);
    // Back-to-back unwinding through the banked SPSRs
    return_seq("b2b_svc", 32'h0000_8004, 5'b10011, 5'b11011, 1'b1, 1'b1);
    return_seq("b2b_und", 32'h0000_7004, 5'b11011, 5'b10111, 1'b1, 1'b1);
    return_seq("b2b_abt", 32'h0000_6004, 5'b10111, 5'b10001, 1'b1, 1'b1);
    return_seq("b2b_fiq", 32'h0000_5004, 5'b10001, 5'b10111, 1'b1, 1'b0);
    test_ret_reject();
    test_reset_abort();
    cyc();
    n_total++; if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exc_seq.md
Name: exc_seq

Overview:
- Exception entry/return sequencer. Master that drives the banked register file's write, PC and mode (M) inputs, and one of its read ports.
- On an exception it switches the processor mode, saves the current status into a per-mode SPSR, writes the banked LR (r14) and loads the vector into PC.
- On a return request it reads the banked LR, restores the saved status and writes PC.
- Sits between the core control unit and the register file; owns the CPSR mode/mask bits.

Parameters:
- VBASE, 32'h0000_0000, exception vector table base address.
- RST_MODE, 5'b10011, mode loaded into M at reset (SVC).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- exc_req  in  6  exception request levels: [0] SVC, [1] UND, [2] PABT, [3] IRQ, [4] FIQ, [5] DABT.
- ret_req  in  1  exception-return request level.
- cur_pc  in  32  address of the current instruction.
- r_data  in  32  read data from the register file port driven by r_addr.
- r_addr  out  4  register file read address.
- write_reg  out  1  register file write enable.
- w_addr  out  4  register file write address.
- w_data  out  32  register file write data.
- write_pc  out  1  PC write enable.
- pc_data  out  32  PC write data.
- M  out  5  current processor mode, to the register file.
- irq_mask  out  1  CPSR I bit.
- fiq_mask  out  1  CPSR F bit.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the final cycle of an entry or return.
- err  out  1  one-cycle pulse when a return is rejected.

Behaviour:
- Reset (rst=0, async): state=IDLE, M=RST_MODE, irq_mask=1, fiq_mask=1, all SPSRs=0, write_reg=write_pc=done=err=busy=0, r_addr=w_addr=0, w_data=pc_data=0.
- SPSRs: 7-bit registers {I,F,M} banked for FIQ, IRQ, SVC, ABT and UND.
- Requests are sampled only in IDLE. Levels held while busy are ignored until IDLE is re-entered.
- Effective requests: IRQ is qualified by !irq_mask, FIQ by !fiq_mask.
- Entry priority, highest first: DABT > FIQ > IRQ > PABT > UND > SVC. Any qualified exception beats ret_req.
- Exception table (target mode, vector offset, LR value):
  - SVC: 10011, 0x08, cur_pc+4
  - UND: 11011, 0x04, cur_pc+4
  - PABT: 10111, 0x0C, cur_pc+4
  - DABT: 10111, 0x10, cur_pc+8
  - IRQ: 10010, 0x18, cur_pc+4
  - FIQ: 10001, 0x1C, cur_pc+4
- All arithmetic is 32-bit wrap-around, with no overflow detection.
- IDLE -> ENT_LR, on the cycle a request is accepted:
  - SPSR[target] <= {I,F,M} (the old values).
  - M <= target mode; I <= 1; F <= 1 for FIQ only, otherwise unchanged.
  - LR value and vector are latched.
- ENT_LR, 1 cycle: write_reg=1, w_addr=14, w_data=latched LR. M already holds the target mode, so the write lands in the banked r14. Next state ENT_PC.
- ENT_PC, 1 cycle: write_pc=1, pc_data=VBASE+offset, done=1. Next state IDLE.
- IDLE -> RET_RD when ret_req=1 and no qualified exception is pending:
  - If M is 10000 (USR) or 11111 (SYS): err=1 for 1 cycle, stay in IDLE, no register activity.
- RET_RD, 1 cycle: r_addr=14, M unchanged. r_data is captured into ret_pc at the end of the cycle. Next state RET_WR.
- RET_WR, 1 cycle: write_pc=1, pc_data=ret_pc, done=1. {I,F,M} <= SPSR[current mode] at the end of the cycle. Next state IDLE.
- Latency: entry is 3 cycles from request to done (IDLE-accept, ENT_LR, ENT_PC). Return is 3 cycles (IDLE-accept, RET_RD, RET_WR).
- write_reg and write_pc are never both high. Outside the states above they are 0. r_addr holds 14 outside IDLE and 0 in IDLE.
- Nested entry (an exception accepted in IDLE while already in an exception mode) is allowed; the SPSR of the new target mode is overwritten.
- Reset mid-sequence aborts immediately; no partial write is issued after rst falls.

Test Plan:
- Reset, then exc_req=6'b000001, cur_pc=0x100 -> M=10011, write_reg with w_addr=14, w_data=0x104, then write_pc with pc_data=0x08, done on cycle 3, SPSR_svc=7'b1110011.
- Clear irq_mask via a return to USR, then exc_req=6'b001000 with cur_pc=0x2000 -> M=10010, I=1, r14 write of 0x2004, pc_data=0x18; the same IRQ with irq_mask=1 -> no activity.
- exc_req=6'b111111 simultaneously -> DABT wins: M=10111, LR=cur_pc+8, pc_data=0x10.
- In IRQ mode with r_data=0x2004 and SPSR_irq=7'b0010000, pulse ret_req -> r_addr=14 in RET_RD, pc_data=0x2004, M=10000, I=0, F=0, done.
- ret_req in USR mode -> err pulse for 1 cycle, busy stays 0, no writes.
- Assert rst low during ENT_LR -> outputs return to reset values asynchronously, write_pc is never asserted.
